// File: rtl/iob_uart_console_bridge.sv
// iob_uart_console_bridge
//
// Hardware replacement for the polled software console loop on an iob_uart.
// After reset it runs the UART init sequence (soft reset pulse, baud divisor,
// TX/RX enable). It then polls RXREADY/TXREADY and moves bytes between the
// UART and two host-side byte streams. Each stream is buffered by a
// first-word fall-through FIFO. RX bytes equal to ENQ (0x05) are flagged.
//
// Ports
//   clk, arst_n        clock, asynchronous active-low reset
//   uart_valid/addr/   bus request towards the iob_uart; all fields are held
//   wdata/wstrb        stable until uart_ready; wstrb == 0 means read
//   uart_rdata/ready   read data and completion, both sampled in one cycle
//   h2u_data/valid/    host-to-UART byte stream (TX FIFO input)
//   h2u_ready
//   u2h_data/valid/    UART-to-host byte stream (RX FIFO head)
//   u2h_ready
//   enq_seen           one-cycle pulse when a received byte equals 0x05
//   init_done          high once the init sequence has completed
module iob_uart_console_bridge #(
    parameter int          DATA_W          = 32,
    parameter int          ADDR_W          = 4,
    parameter int          FIFO_DEPTH_LOG2 = 3,
    parameter logic [15:0] UART_DIV        = 16'd434,
    parameter int          POLL_GAP        = 4,
    parameter int          SOFTRESET_ADDR  = 0,
    parameter int          DIV_ADDR        = 2,
    parameter int          TXDATA_ADDR     = 4,
    parameter int          TXEN_ADDR       = 5,
    parameter int          TXREADY_ADDR    = 6,
    parameter int          RXDATA_ADDR     = 7,
    parameter int          RXEN_ADDR       = 8,
    parameter int          RXREADY_ADDR    = 9
) (
    input  logic                clk,
    input  logic                arst_n,
    output logic                uart_valid,
    output logic [ADDR_W-1:0]   uart_addr,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_ready,
    input  logic [7:0]          h2u_data,
    input  logic                h2u_valid,
    output logic                h2u_ready,
    output logic [7:0]          u2h_data,
    output logic                u2h_valid,
    input  logic                u2h_ready,
    output logic                enq_seen,
    output logic                init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << PW;
    localparam int RX    = 0;
    localparam int TX    = 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [NB-1:0]     strb_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [PW:0]       ptr_t;

    typedef enum logic [3:0] {
        INIT_SR1,
        INIT_SR0,
        INIT_DIV,
        INIT_TXEN,
        INIT_RXEN,
        IDLE,
        POLL_RX,
        RD_RX,
        POLL_TX,
        WR_TX
    } state_t;

    // Registers are narrower than the bus: each access uses the byte lane
    // selected by the low address bits.
    function automatic data_t lane_data(input addr_t addr, input logic [15:0] value);
        int lane;
        lane = int'(addr) % NB;
        return data_t'(value) << (8 * lane);
    endfunction

    function automatic strb_t lane_strb(input addr_t addr, input logic wide);
        int lane;
        lane = int'(addr) % NB;
        return strb_t'(wide ? 2'b11 : 2'b01) << lane;
    endfunction

    function automatic logic [7:0] lane_byte(input addr_t addr, input data_t rdata);
        data_t shifted;
        shifted = rdata >> (8 * (int'(addr) % NB));
        return shifted[7:0];
    endfunction

    state_t      state, state_next;
    logic        run;
    logic [15:0] gap_cnt;
    logic        gap_done;
    logic        done;

    logic        req, req_write, req_wide;
    addr_t       req_addr;
    logic [15:0] req_value;
    logic [7:0]  rd_byte;
    logic        rx_push, tx_pop, set_init_done;

    logic [1:0]       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0][7:0]  fifo_wdata, fifo_head;

    // run is the only thing gating the bus: it clears asynchronously, so a
    // request in flight is withdrawn the instant arst_n falls, and it stays
    // low for the first cycle after release.
    assign done     = run && uart_ready;
    assign gap_done = gap_cnt >= 16'(POLL_GAP);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking assignments here would make results depend
    // on statement and process ordering.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= INIT_SR1;
            run       <= 1'b0;
            gap_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
            if (state != IDLE || gap_done) gap_cnt <= '0;
            else                           gap_cnt <= gap_cnt + 16'd1;
            if (set_init_done) init_done <= 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        req           = 1'b0;
        req_write     = 1'b0;
        req_wide      = 1'b0;
        req_addr      = '0;
        req_value     = '0;
        rd_byte       = '0;
        rx_push       = 1'b0;
        tx_pop        = 1'b0;
        set_init_done = 1'b0;
        enq_seen      = 1'b0;

        unique case (state)
            INIT_SR1: begin
                req = 1'b1; req_write = 1'b1;
                req_addr = addr_t'(SOFTRESET_ADDR); req_value = 16'd1;
                if (done) state_next = INIT_SR0;
            end
            INIT_SR0: begin
                req = 1'b1; req_write = 1'b1;
                req_addr = addr_t'(SOFTRESET_ADDR); req_value = 16'd0;
                if (done) state_next = INIT_DIV;
            end
            INIT_DIV: begin
                req = 1'b1; req_write = 1'b1; req_wide = 1'b1;
                req_addr = addr_t'(DIV_ADDR); req_value = UART_DIV;
                if (done) state_next = INIT_TXEN;
            end
            INIT_TXEN: begin
                req = 1'b1; req_write = 1'b1;
                req_addr = addr_t'(TXEN_ADDR); req_value = 16'd1;
                if (done) state_next = INIT_RXEN;
            end
            INIT_RXEN: begin
                req = 1'b1; req_write = 1'b1;
                req_addr = addr_t'(RXEN_ADDR); req_value = 16'd1;
                if (done) begin
                    set_init_done = 1'b1;
                    state_next    = IDLE;
                end
            end
            // FIFO status is only consulted when choosing the next poll, never
            // while a transaction is pending.
            IDLE: begin
                if (gap_done) begin
                    if (!fifo_full[RX])       state_next = POLL_RX;
                    else if (!fifo_empty[TX]) state_next = POLL_TX;
                end
            end
            POLL_RX: begin
                req = 1'b1; req_addr = addr_t'(RXREADY_ADDR);
                rd_byte = lane_byte(req_addr, uart_rdata);
                if (done) begin
                    if (rd_byte[0])           state_next = RD_RX;
                    else if (!fifo_empty[TX]) state_next = POLL_TX;
                    else                      state_next = IDLE;
                end
            end
            RD_RX: begin
                req = 1'b1; req_addr = addr_t'(RXDATA_ADDR);
                rd_byte = lane_byte(req_addr, uart_rdata);
                if (done) begin
                    rx_push    = 1'b1;
                    enq_seen   = (rd_byte == 8'h05);
                    state_next = fifo_empty[TX] ? IDLE : POLL_TX;
                end
            end
            POLL_TX: begin
                req = 1'b1; req_addr = addr_t'(TXREADY_ADDR);
                rd_byte = lane_byte(req_addr, uart_rdata);
                if (done) state_next = rd_byte[0] ? WR_TX : IDLE;
            end
            WR_TX: begin
                req = 1'b1; req_write = 1'b1;
                req_addr = addr_t'(TXDATA_ADDR); req_value = {8'h00, fifo_head[TX]};
                if (done) begin
                    tx_pop     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = INIT_SR1;
        endcase

        uart_valid = run && req;
        uart_addr  = uart_valid ? req_addr : '0;
        uart_wdata = (uart_valid && req_write) ? lane_data(req_addr, req_value) : '0;
        uart_wstrb = (uart_valid && req_write) ? lane_strb(req_addr, req_wide) : '0;
    end

    assign h2u_ready  = init_done && !fifo_full[TX];
    assign u2h_valid  = !fifo_empty[RX];
    assign u2h_data   = fifo_head[RX];

    assign fifo_push  = {h2u_valid && h2u_ready, rx_push};
    assign fifo_pop   = {tx_pop, u2h_ready};
    assign fifo_wdata = {h2u_data, rd_byte};

    // Two identical FWFT FIFOs (index RX, TX). The extra pointer bit tells
    // full from empty when the wrapped indices match.
    for (genvar f = 0; f < 2; f++) begin : g_fifo
        logic [7:0] mem [DEPTH];
        ptr_t       wr_ptr, rd_ptr;
        logic       do_push, do_pop;

        assign fifo_empty[f] = (wr_ptr == rd_ptr);
        assign fifo_full[f]  = (wr_ptr[PW] != rd_ptr[PW]) &&
                               (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
        assign fifo_head[f]  = mem[rd_ptr[PW-1:0]];

        // A pop frees the slot a same-cycle push needs, so a full FIFO still
        // accepts a push while it is being popped.
        assign do_pop  = fifo_pop[f] && !fifo_empty[f];
        assign do_push = fifo_push[f] && (!fifo_full[f] || do_pop);

        // NOTE: the storage is reset together with the pointers so that every
        // flop clears on arst_n; a RAM-macro mapping would drop this loop.
        always_ff @(posedge clk or negedge arst_n) begin
            if (!arst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else begin
                if (do_push) begin
                    mem[wr_ptr[PW-1:0]] <= fifo_wdata[f];
                    wr_ptr              <= wr_ptr + 1'b1;
                end
                if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iob_uart_console_bridge.sv
// Testbench for iob_uart_console_bridge: a behavioural iob_uart answers bus
// requests on the falling edge, a host model feeds and drains the byte
// streams, and directed vectors plus a few multi-cycle sequences are checked.
module tb_iob_uart_console_bridge;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
        int         enq;
    } rx_vec_t;

    logic        clk;
    logic        arst_n;
    logic        uart_valid;
    logic [3:0]  uart_addr;
    logic [31:0] uart_wdata;
    logic [3:0]  uart_wstrb;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic [7:0]  h2u_data;
    logic        h2u_valid;
    logic        h2u_ready;
    logic [7:0]  u2h_data;
    logic        u2h_valid;
    logic        u2h_ready;
    logic        enq_seen;
    logic        init_done;

    int n_err    = 0;
    int n_checks = 0;
    int cyc      = 0;
    int enq_cnt  = 0;
    int h2u_drop = 0;
    bit stall_tx = 0;
    bit tx_watch = 0;
    bit txready  = 1;

    logic [7:0] rx_q[$];
    logic [7:0] rx_got[$];
    int         rx_got_cyc[$];
    int         rd_cyc[$];
    bus_t       bus_log[$];
    bus_t       tx_log[$];

    bus_t    init_vec[5];
    rx_vec_t rx_vec[6];

    iob_uart_console_bridge dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .uart_valid (uart_valid),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .h2u_data   (h2u_data),
        .h2u_valid  (h2u_valid),
        .h2u_ready  (h2u_ready),
        .u2h_data   (u2h_data),
        .u2h_valid  (u2h_valid),
        .u2h_ready  (u2h_ready),
        .enq_seen   (enq_seen),
        .init_done  (init_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        bus_log.delete();
        tx_log.delete();
        rx_got.delete();
        rx_got_cyc.delete();
        rd_cyc.delete();
        enq_cnt = 0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
        #3;
    endtask

    function automatic int count_addr(input logic [3:0] a);
        int n;
        n = 0;
        foreach (bus_log[i]) if (bus_log[i].addr == a) n++;
        return n;
    endfunction

    task automatic push_h2u(input logic [7:0] b);
        int k;
        @(posedge clk); #1;
        h2u_data  = b;
        h2u_valid = 1'b1;
        k = 0;
        do begin
            @(negedge clk); #3;
            k++;
        end while (!h2u_ready && k < 100);
        check("h2u_accept", {31'b0, h2u_ready}, 32'd1);
        @(posedge clk); #1;
        h2u_valid = 1'b0;
    endtask

    // UART register model plus host-side monitors, all on the falling edge.
    // A request seen here completes at the next rising edge.
    initial begin
        logic [7:0] rsp;
        int         lane;
        uart_ready = 1'b0;
        uart_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            uart_ready = 1'b0;
            uart_rdata = '0;
            if (arst_n && uart_valid && !(stall_tx && uart_addr == 4'd4)) begin
                uart_ready = 1'b1;
                bus_log.push_back('{uart_addr, uart_wdata, uart_wstrb});
                if (uart_wstrb == 4'b0000) begin
                    rsp = 8'h00;
                    case (uart_addr)
                        4'd9: rsp = {7'b0, rx_q.size() != 0};
                        4'd7: begin
                            if (rx_q.size() != 0) rsp = rx_q.pop_front();
                            rd_cyc.push_back(cyc);
                        end
                        4'd6: rsp = {7'b0, txready};
                        default: rsp = 8'h00;
                    endcase
                    lane = int'(uart_addr[1:0]);
                    uart_rdata = 32'hFEFE_FEFE;
                    uart_rdata[8*lane +: 8] = rsp;
                end else if (uart_addr == 4'd4) begin
                    tx_log.push_back('{uart_addr, uart_wdata, uart_wstrb});
                end
            end
            if (u2h_valid && u2h_ready) begin
                rx_got.push_back(u2h_data);
                rx_got_cyc.push_back(cyc);
            end
            if (tx_watch && !h2u_ready) h2u_drop++;
            #1;
            if (enq_seen) enq_cnt++;
        end
    end

    initial begin
        int k;
        int snap;
        int found;

        init_vec[0] = '{addr: 4'd0, wdata: 32'h0000_0001, wstrb: 4'b0001};
        init_vec[1] = '{addr: 4'd0, wdata: 32'h0000_0000, wstrb: 4'b0001};
        init_vec[2] = '{addr: 4'd2, wdata: 32'h01B2_0000, wstrb: 4'b1100};
        init_vec[3] = '{addr: 4'd5, wdata: 32'h0000_0100, wstrb: 4'b0010};
        init_vec[4] = '{addr: 4'd8, wdata: 32'h0000_0001, wstrb: 4'b0001};

        rx_vec[0] = '{8'h41, 8'h41, 0};
        rx_vec[1] = '{8'h05, 8'h05, 1};
        rx_vec[2] = '{8'h00, 8'h00, 0};
        rx_vec[3] = '{8'hFF, 8'hFF, 0};
        rx_vec[4] = '{8'h85, 8'h85, 0};
        rx_vec[5] = '{8'h04, 8'h04, 0};

        arst_n    = 1'b1;
        h2u_data  = 8'h00;
        h2u_valid = 1'b0;
        u2h_ready = 1'b1;
        #2 arst_n = 1'b0;

        // Reset state
        idle_cycles(3);
        check("rst_uart_valid", {31'b0, uart_valid}, 32'd0);
        check("rst_uart_addr",  {28'b0, uart_addr},  32'd0);
        check("rst_uart_wdata", uart_wdata,          32'd0);
        check("rst_uart_wstrb", {28'b0, uart_wstrb}, 32'd0);
        check("rst_h2u_ready",  {31'b0, h2u_ready},  32'd0);
        check("rst_u2h_valid",  {31'b0, u2h_valid},  32'd0);
        check("rst_enq_seen",   {31'b0, enq_seen},   32'd0);
        check("rst_init_done",  {31'b0, init_done},  32'd0);

        // Init sequence
        clear_logs();
        @(posedge clk); #1 arst_n = 1'b1;
        k = 0;
        do begin
            @(negedge clk); #3;
            k++;
        end while (bus_log.size() < 5 && k < 100);
        check("init_writes", bus_log.size(), 32'd5);
        check("init_done_in_rxen_cycle", {31'b0, init_done}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("init%0d_addr", i),  {28'b0, bus_log[i].addr},  {28'b0, init_vec[i].addr});
            check($sformatf("init%0d_wdata", i), bus_log[i].wdata,          init_vec[i].wdata);
            check($sformatf("init%0d_wstrb", i), {28'b0, bus_log[i].wstrb}, {28'b0, init_vec[i].wstrb});
        end
        idle_cycles(1);
        check("init_done_after_rxen", {31'b0, init_done}, 32'd1);
        check("h2u_ready_after_init", {31'b0, h2u_ready}, 32'd1);

        // RX vectors, host always ready
        for (int i = 0; i < 6; i++) begin
            clear_logs();
            @(posedge clk); #1 rx_q.push_back(rx_vec[i].din);
            k = 0;
            while (rx_got.size() < 1 && k < 200) begin
                @(negedge clk); #3;
                k++;
            end
            check($sformatf("rx%0d_count", i), rx_got.size(), 32'd1);
            check($sformatf("rx%0d_data", i), {24'b0, (rx_got.size() > 0) ? rx_got[0] : 8'hxx},
                  {24'b0, rx_vec[i].dout});
            check($sformatf("rx%0d_latency", i),
                  (rx_got.size() > 0 && rd_cyc.size() > 0) ? rx_got_cyc[0] - rd_cyc[0] : -1, 32'd1);
            check($sformatf("rx%0d_enq_cycles", i), enq_cnt, rx_vec[i].enq);
            found = 0;
            foreach (bus_log[j])
                if (bus_log[j].addr == 4'd7 && bus_log[j].wstrb == 4'b0000 && bus_log[j].wdata == 32'd0)
                    found++;
            check($sformatf("rx%0d_rxdata_read", i), found, 32'd1);
            idle_cycles(1);
            check($sformatf("rx%0d_drained", i), {31'b0, u2h_valid}, 32'd0);
        end

        // TX: two bytes, TXREADY=1
        clear_logs();
        h2u_drop = 0;
        tx_watch = 1'b1;
        push_h2u(8'h68);
        push_h2u(8'h69);
        k = 0;
        while (tx_log.size() < 2 && k < 300) begin
            @(negedge clk); #3;
            k++;
        end
        tx_watch = 1'b0;
        check("tx_count", tx_log.size(), 32'd2);
        check("tx0_wdata", (tx_log.size() > 0) ? tx_log[0].wdata : 32'hx, 32'h0000_0068);
        check("tx0_wstrb", (tx_log.size() > 0) ? {28'b0, tx_log[0].wstrb} : 32'hx, 32'd1);
        check("tx1_wdata", (tx_log.size() > 1) ? tx_log[1].wdata : 32'hx, 32'h0000_0069);
        check("tx1_wstrb", (tx_log.size() > 1) ? {28'b0, tx_log[1].wstrb} : 32'hx, 32'd1);
        check("tx_h2u_ready_drops", h2u_drop, 32'd0);

        // TX with TXREADY=0: byte is held until the UART reports ready
        clear_logs();
        txready = 1'b0;
        push_h2u(8'h70);
        idle_cycles(100);
        check("txbusy_no_write", tx_log.size(), 32'd0);
        check("txbusy_polled", {31'b0, count_addr(4'd6) > 0}, 32'd1);
        txready = 1'b1;
        k = 0;
        while (tx_log.size() < 1 && k < 200) begin
            @(negedge clk); #3;
            k++;
        end
        check("txbusy_wdata", (tx_log.size() > 0) ? tx_log[0].wdata : 32'hx, 32'h0000_0070);

        // RX overflow: nine bytes, host stalled, depth 8
        clear_logs();
        @(posedge clk); #1 u2h_ready = 1'b0;
        for (int i = 0; i < 9; i++) rx_q.push_back(8'h31 + 8'(i));
        k = 0;
        while (rd_cyc.size() < 8 && k < 500) begin
            @(negedge clk); #3;
            k++;
        end
        snap = count_addr(4'd9);
        idle_cycles(100);
        check("ovf_reads", rd_cyc.size(), 32'd8);
        check("ovf_no_poll_when_full", count_addr(4'd9), snap);
        check("ovf_left_in_uart", rx_q.size(), 32'd1);
        check("ovf_u2h_valid", {31'b0, u2h_valid}, 32'd1);
        check("ovf_head", {24'b0, u2h_data}, 32'h31);
        @(posedge clk); #1 u2h_ready = 1'b1;
        k = 0;
        while (rx_got.size() < 9 && k < 500) begin
            @(negedge clk); #3;
            k++;
        end
        check("ovf_delivered", rx_got.size(), 32'd9);
        for (int i = 0; i < 9; i++)
            check($sformatf("ovf_byte%0d", i), {24'b0, (rx_got.size() > i) ? rx_got[i] : 8'hxx},
                  32'h31 + i);

        // Reset while a TXDATA write is stalled
        clear_logs();
        @(posedge clk); #1 u2h_ready = 1'b0;
        rx_q.push_back(8'h55);
        k = 0;
        while (!u2h_valid && k < 200) begin
            @(negedge clk); #3;
            k++;
        end
        check("rst2_rx_buffered", {31'b0, u2h_valid}, 32'd1);
        stall_tx = 1'b1;
        push_h2u(8'h77);
        push_h2u(8'h78);
        k = 0;
        while (!(uart_valid && uart_addr == 4'd4) && k < 300) begin
            @(negedge clk); #3;
            k++;
        end
        idle_cycles(3);
        check("rst2_stalled_valid", {31'b0, uart_valid}, 32'd1);
        check("rst2_stalled_addr",  {28'b0, uart_addr},  32'd4);
        check("rst2_stalled_wdata", uart_wdata,          32'h0000_0077);
        check("rst2_stalled_wstrb", {28'b0, uart_wstrb}, 32'd1);
        @(posedge clk); #1 arst_n = 1'b0;
        #1;
        check("rst2_valid_drop", {31'b0, uart_valid}, 32'd0);
        check("rst2_wstrb_clear", {28'b0, uart_wstrb}, 32'd0);
        check("rst2_u2h_valid",   {31'b0, u2h_valid},  32'd0);
        check("rst2_h2u_ready",   {31'b0, h2u_ready},  32'd0);
        check("rst2_init_done",   {31'b0, init_done},  32'd0);
        idle_cycles(2);
        stall_tx = 1'b0;
        clear_logs();
        @(posedge clk); #1 arst_n = 1'b1;
        k = 0;
        while (bus_log.size() < 1 && k < 50) begin
            @(negedge clk); #3;
            k++;
        end
        check("rst2_first_addr",  (bus_log.size() > 0) ? {28'b0, bus_log[0].addr}  : 32'hx, 32'd0);
        check("rst2_first_wdata", (bus_log.size() > 0) ? bus_log[0].wdata          : 32'hx, 32'd1);
        check("rst2_first_wstrb", (bus_log.size() > 0) ? {28'b0, bus_log[0].wstrb} : 32'hx, 32'd1);
        idle_cycles(150);
        check("rst2_reinit_done", {31'b0, init_done}, 32'd1);
        check("rst2_rx_flushed",  {31'b0, u2h_valid}, 32'd0);
        check("rst2_tx_no_write", count_addr(4'd4), 32'd0);
        check("rst2_tx_no_poll",  count_addr(4'd6), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
